mips_prog_loader: RTL



---
 rtl/mips_loader_pkg.sv | 17 +
 rtl/loader_checker.sv | 50 +++++
 rtl/mips_prog_loader.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/mips_loader_pkg.sv
// Shared types and constants for the MIPS32 program loader and its bench.
package mips_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REG_INIT,
    LOAD,
    RUN,
    CHECK_ADDR,
    CHECK_CMP,
    DONE
  } state_e;

  localparam logic [2:0] FAIL_TIMEOUT = 3'd7;
  localparam logic [5:0] HALT_OP      = 6'h3f;

endpackage

// File: rtl/loader_checker.sv
// Result-check sequencer: walks the check slots, compares read data and
// records the index of the first mismatching slot.
module loader_checker
  import mips_loader_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 10,
  parameter int NUM_CHECKS = 1
) (
  input  logic                           clk1,
  input  logic                           rst_n,
  input  logic                           clr_i,
  input  logic                           cmp_i,
  input  logic                           timeout_i,
  input  logic [NUM_CHECKS*ADDR_W-1:0]   chk_addr_i,
  input  logic [NUM_CHECKS*DATA_W-1:0]   chk_data_i,
  input  logic [DATA_W-1:0]              mem_rdata_i,
  output logic [ADDR_W-1:0]              addr_o,
  output logic                           match_o,
  output logic                           last_o,
  output logic [2:0]                     fail_idx_o
);

  logic [2:0] slot_q;
  logic [2:0] fail_idx_q;

  assign addr_o     = chk_addr_i[int'(slot_q)*ADDR_W +: ADDR_W];
  assign match_o    = (mem_rdata_i == chk_data_i[int'(slot_q)*DATA_W +: DATA_W]);
  assign last_o     = (slot_q == 3'(NUM_CHECKS - 1));
  assign fail_idx_o = fail_idx_q;

  // The slot only advances on a match, so on a mismatch it still names the failing slot.
  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      slot_q     <= 3'd0;
      fail_idx_q <= 3'd0;
    end else if (clr_i) begin
      slot_q     <= 3'd0;
      fail_idx_q <= 3'd0;
    end else if (timeout_i) begin
      fail_idx_q <= FAIL_TIMEOUT;
    end else if (cmp_i) begin
      if (!match_o)
        fail_idx_q <= slot_q;
      else if (!last_o)
        slot_q <= slot_q + 3'd1;
    end
  end

endmodule

// File: rtl/mips_prog_loader.sv
// MIPS32 harness controller: register init, image load, run, result check.
// Optional RUN-state watchdog enabled by defining LOADER_WATCHDOG_EN.
module mips_prog_loader
  import mips_loader_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 10,
  parameter int NUM_REGS   = 32,
  parameter int NUM_CHECKS = 1,
  parameter int TIMEOUT    = 4096
) (
  input  logic                         clk1,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         ld_valid,
  output logic                         ld_ready,
  input  logic [ADDR_W-1:0]            ld_addr,
  input  logic [DATA_W-1:0]            ld_data,
  input  logic                         ld_last,
  output logic                         mem_we,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic [DATA_W-1:0]            mem_wdata,
  input  logic [DATA_W-1:0]            mem_rdata,
  output logic                         reg_we,
  output logic [4:0]                   reg_waddr,
  output logic [DATA_W-1:0]            reg_wdata,
  output logic                         cpu_run,
  input  logic                         cpu_halted,
  input  logic [NUM_CHECKS*ADDR_W-1:0] chk_addr,
  input  logic [NUM_CHECKS*DATA_W-1:0] chk_data,
  output logic                         done,
  output logic                         pass,
  output logic [2:0]                   fail_idx,
  output logic [31:0]                  cycles
`ifdef LOADER_WATCHDOG_EN
  ,
  output logic                         timeout
`endif
);

  if (NUM_CHECKS < 1 || NUM_CHECKS > 8 || NUM_REGS < 1 || NUM_REGS > 32 ||
      TIMEOUT < 1) begin : g_bad_params
    $error("mips_prog_loader: parameter out of range");
  end

  state_e      state_q;
  logic [5:0]  reg_idx_q;
  logic        reg_we_q;
  logic        ld_ready_q;
  logic        cpu_run_q;
  logic        done_q;
  logic        pass_q;
  logic [31:0] cycles_q;
  logic        wd_hit;
  logic        start_ok;
  logic        chk_active;
  logic [ADDR_W-1:0] chk_mem_addr;
  logic        chk_match;
  logic        chk_last;

`ifdef LOADER_WATCHDOG_EN
  logic timeout_q;
  assign wd_hit  = (state_q == RUN) && !cpu_halted && (cycles_q >= 32'(TIMEOUT - 1));
  assign timeout = timeout_q;
`else
  assign wd_hit  = 1'b0;
`endif

  assign start_ok   = (state_q == IDLE) && start;
  assign chk_active = (state_q == CHECK_ADDR) || (state_q == CHECK_CMP);

  loader_checker #(
    .DATA_W     (DATA_W),
    .ADDR_W     (ADDR_W),
    .NUM_CHECKS (NUM_CHECKS)
  ) u_checker (
    .clk1        (clk1),
    .rst_n       (rst_n),
    .clr_i       (start_ok),
    .cmp_i       (state_q == CHECK_CMP),
    .timeout_i   (wd_hit),
    .chk_addr_i  (chk_addr),
    .chk_data_i  (chk_data),
    .mem_rdata_i (mem_rdata),
    .addr_o      (chk_mem_addr),
    .match_o     (chk_match),
    .last_o      (chk_last),
    .fail_idx_o  (fail_idx)
  );

  // Image beats pass straight through to memory so a write lands in the accept cycle.
  assign ld_ready  = ld_ready_q;
  assign mem_we    = ld_ready_q & ld_valid;
  assign mem_addr  = ld_ready_q ? ld_addr : (chk_active ? chk_mem_addr : '0);
  assign mem_wdata = ld_ready_q ? ld_data : '0;

  assign reg_we    = reg_we_q;
  assign reg_waddr = reg_idx_q[4:0];
  assign reg_wdata = {{(DATA_W-6){1'b0}}, reg_idx_q};
  assign cpu_run   = cpu_run_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign cycles    = cycles_q;

  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      reg_idx_q  <= 6'd0;
      reg_we_q   <= 1'b0;
      ld_ready_q <= 1'b0;
      cpu_run_q  <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      cycles_q   <= 32'd0;
`ifdef LOADER_WATCHDOG_EN
      timeout_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q   <= REG_INIT;
            reg_we_q  <= 1'b1;
            reg_idx_q <= 6'd0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            cycles_q  <= 32'd0;
`ifdef LOADER_WATCHDOG_EN
            timeout_q <= 1'b0;
`endif
          end
        end
        REG_INIT: begin
          if (reg_idx_q == 6'(NUM_REGS - 1)) begin
            reg_we_q   <= 1'b0;
            ld_ready_q <= 1'b1;
            state_q    <= LOAD;
          end else begin
            reg_idx_q <= reg_idx_q + 6'd1;
          end
        end
        LOAD: begin
          if (ld_valid && ld_last) begin
            ld_ready_q <= 1'b0;
            cpu_run_q  <= 1'b1;
            state_q    <= RUN;
          end
        end
        RUN: begin
          if (cycles_q != 32'hffff_ffff)
            cycles_q <= cycles_q + 32'd1;
          if (cpu_halted) begin
            cpu_run_q <= 1'b0;
            state_q   <= CHECK_ADDR;
          end else if (wd_hit) begin
            cpu_run_q <= 1'b0;
            done_q    <= 1'b1;
            pass_q    <= 1'b0;
`ifdef LOADER_WATCHDOG_EN
            timeout_q <= 1'b1;
`endif
            state_q   <= DONE;
          end
        end
        CHECK_ADDR: state_q <= CHECK_CMP;
        CHECK_CMP: begin
          if (!chk_match || chk_last) begin
            pass_q  <= chk_match;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            state_q <= CHECK_ADDR;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
